// File: rtl/seg_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
// Segment patterns are active-high with bit 0 = segment a through bit 6 = g, bit 7 = dp.
package seg_pkg;

    typedef enum logic {
        DWELL,
        BLANK
    } scan_state_e;

    typedef enum logic [1:0] {
        SRC_TIME,
        SRC_PEND,
        SRC_MSG
    } src_e;

    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
        digit_onehot = 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/seg_bcd_decoder.sv
// Combinational BCD to active-high a..g decoder; non-decimal codes decode to blank.
module seg_bcd_decoder
    import seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // NOTE: seg gets a value before the case so no path leaves it unassigned (no latch).
    always_comb begin
        seg = SEG_OFF;
        case (bcd)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Digit scan sequencer with blank gaps, PWM dimming and frame-aligned arbitration
// between the live mm:ss time and a timed raw-segment message.
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int CC           = 1,
    parameter int FREQ         = 2000,
    parameter int SCAN_PER_SEC = 25,
    parameter int BLANK_CYC    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] time_bcd,
    input  logic        msg_req,
    input  logic [31:0] msg_data,
    input  logic [7:0]  msg_frames,
    input  logic [3:0]  brightness,
    output logic [7:0]  seven_seg,
    output logic [3:0]  digit_en,
    output logic        msg_busy,
    output logic        frame_done
);

    localparam int DIG_RAW      = FREQ / (4 * SCAN_PER_SEC);
    localparam int DIG_DURATION = (DIG_RAW < 1) ? 1 : DIG_RAW;
    localparam int CNT_MAX      = (DIG_DURATION > BLANK_CYC) ? DIG_DURATION : BLANK_CYC;
    localparam int CNT_W        = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DIG_DURATION - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    localparam logic [7:0] SEG_RST = (CC != 0) ? 8'h00 : 8'hFF;
    localparam logic [3:0] DEN_RST = (CC != 0) ? 4'hF  : 4'h0;

    scan_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       dig_q, dig_d;
    logic [3:0]       pwm_q, pwm_d;
    src_e             src_q, src_d;
    logic [7:0]       frames_left_q, frames_left_d;
    logic [31:0]      msg_data_q, msg_data_d;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       den_q, den_d;

    logic             frame_end;
    logic [3:0]       time_nib;
    logic [6:0]       time_seg;
    logic [7:0]       pattern;
    logic [7:0]       seg_act;
    logic [3:0]       den_act;
    logic             lit;

    // Scan FSM: DWELL for DIG_DURATION cycles, then an optional BLANK gap.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        dig_d     = dig_q;
        frame_end = 1'b0;
        case (state_q)
            DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (BLANK_CYC == 0) begin
                        dig_d     = dig_q + 2'd1;
                        frame_end = (dig_q == 2'd3);
                    end else begin
                        state_d = BLANK;
                    end
                end
            end
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    cnt_d     = '0;
                    state_d   = DWELL;
                    dig_d     = dig_q + 2'd1;
                    frame_end = (dig_q == 2'd3);
                end
            end
            default: begin
                state_d = DWELL;
                cnt_d   = '0;
            end
        endcase
    end

    assign pwm_d = pwm_q + 4'd1;

    // Source arbitration: switches only on frame_end, so a new source always starts at digit 0.
    always_comb begin
        src_d         = src_q;
        frames_left_d = frames_left_q;
        msg_data_d    = msg_data_q;
        case (src_q)
            SRC_TIME: begin
                if (msg_req && (msg_frames != 8'd0)) begin
                    src_d         = SRC_PEND;
                    msg_data_d    = msg_data;
                    frames_left_d = msg_frames;
                end
            end
            SRC_PEND: begin
                if (frame_end) begin
                    src_d = SRC_MSG;
                end
            end
            SRC_MSG: begin
                if (frame_end) begin
                    frames_left_d = frames_left_q - 8'd1;
                    if (frames_left_q == 8'd1) begin
                        src_d = SRC_TIME;
                    end
                end
            end
            default: src_d = SRC_TIME;
        endcase
    end

    assign time_nib = time_bcd[{dig_q, 2'b00} +: 4];

    seg_bcd_decoder u_bcd_dec (
        .bcd (time_nib),
        .seg (time_seg)
    );

    always_comb begin
        pattern = '0;
        if (src_q == SRC_MSG) begin
            pattern = msg_data_q[{dig_q, 3'b000} +: 8];
        end else begin
            pattern[SEG_G:SEG_A] = time_seg;
            pattern[SEG_DP]      = 1'b0;
        end
        lit     = (state_q == DWELL) && ((brightness == 4'hF) || (pwm_q < brightness));
        seg_act = lit ? pattern : {1'b0, SEG_OFF};
        den_act = lit ? digit_onehot(dig_q) : 4'h0;
        if (CC != 0) begin
            seg_d = seg_act;
            den_d = ~den_act;
        end else begin
            seg_d = ~seg_act;
            den_d = den_act;
        end
    end

    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= DWELL;
            cnt_q         <= '0;
            dig_q         <= 2'd0;
            pwm_q         <= 4'd0;
            src_q         <= SRC_TIME;
            frames_left_q <= 8'd0;
            seg_q         <= SEG_RST;
            den_q         <= DEN_RST;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dig_q         <= dig_d;
            pwm_q         <= pwm_d;
            src_q         <= src_d;
            frames_left_q <= frames_left_d;
            seg_q         <= seg_d;
            den_q         <= den_d;
        end
    end

    // NOTE: payload register has no reset; it is only read while src_q is SRC_MSG, after a load.
    always_ff @(posedge clk) begin
        msg_data_q <= msg_data_d;
    end

    assign seven_seg  = seg_q;
    assign digit_en   = den_q;
    assign msg_busy   = (src_q != SRC_TIME);
    assign frame_done = frame_end;

endmodule

// File: tb/tb_seg_scan_scheduler.sv
// Directed bench: common-cathode and common-anode instances driven in lockstep,
// DIG_DURATION=4, BLANK_CYC=2 (24-cycle frames).
module tb_seg_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] time_bcd;
    logic        msg_req;
    logic [31:0] msg_data;
    logic [7:0]  msg_frames;
    logic [3:0]  brightness;

    logic [7:0]  seg_cc, seg_ca;
    logic [3:0]  den_cc, den_ca;
    logic        busy_cc, busy_ca, fd_cc, fd_ca;

    int n_checks = 0;
    int n_errors = 0;
    int k;

    always #5 clk = ~clk;

    seg_scan_scheduler #(.CC(1), .FREQ(400), .SCAN_PER_SEC(25), .BLANK_CYC(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_bcd   (time_bcd),
        .msg_req    (msg_req),
        .msg_data   (msg_data),
        .msg_frames (msg_frames),
        .brightness (brightness),
        .seven_seg  (seg_cc),
        .digit_en   (den_cc),
        .msg_busy   (busy_cc),
        .frame_done (fd_cc)
    );

    seg_scan_scheduler #(.CC(0), .FREQ(400), .SCAN_PER_SEC(25), .BLANK_CYC(2)) dut_ca (
        .clk        (clk),
        .rst_n      (rst_n),
        .time_bcd   (time_bcd),
        .msg_req    (msg_req),
        .msg_data   (msg_data),
        .msg_frames (msg_frames),
        .brightness (brightness),
        .seven_seg  (seg_ca),
        .digit_en   (den_ca),
        .msg_busy   (busy_ca),
        .frame_done (fd_ca)
    );

    typedef struct {
        int          cyc;
        logic        req;
        logic [31:0] data;
        logic [7:0]  frames;
        logic        chk_out;
        logic [3:0]  den;
        logic [7:0]  seg;
        logic        chk_fd;
        logic        fd;
        logic        chk_busy;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Cycle k = sample taken 1 ns after the k-th rising edge since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        msg_req = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [3:0] den, input logic [7:0] seg);
        logic [3:0] den_inv;
        logic [7:0] seg_inv;
        den_inv = ~den;
        seg_inv = ~seg;
        check($sformatf("%s k%0d cc digit_en", tag, k), den_cc, den);
        check($sformatf("%s k%0d cc seven_seg", tag, k), seg_cc, seg);
        check($sformatf("%s k%0d ca digit_en", tag, k), den_ca, den_inv);
        check($sformatf("%s k%0d ca seven_seg", tag, k), seg_ca, seg_inv);
    endtask

    function automatic vec_t mk(input int c);
        vec_t v;
        v.cyc = c;      v.req = 1'b0;     v.data = '0;    v.frames = '0;
        v.chk_out = 0;  v.den = '0;       v.seg = '0;
        v.chk_fd = 0;   v.fd = 1'b0;      v.chk_busy = 0; v.busy = 1'b0;
        return v;
    endfunction

    task automatic add_out(input int c, input logic [3:0] den, input logic [7:0] seg);
        vec_t v = mk(c);
        v.chk_out = 1'b1; v.den = den; v.seg = seg;
        vecs.push_back(v);
    endtask

    task automatic add_stat(input int c, input logic fd, input logic busy);
        vec_t v = mk(c);
        v.chk_fd = 1'b1; v.fd = fd; v.chk_busy = 1'b1; v.busy = busy;
        vecs.push_back(v);
    endtask

    task automatic add_req(input int c, input logic [31:0] data, input logic [7:0] frames);
        vec_t v = mk(c);
        v.req = 1'b1; v.data = data; v.frames = frames;
        vecs.push_back(v);
    endtask

    initial begin
        int bad;
        time_bcd   = 16'h1234;
        brightness = 4'hF;
        msg_req    = 1'b0;
        msg_data   = '0;
        msg_frames = '0;

        // Scan pattern for time 12:34 at full brightness
        add_out(0, 4'hE, 8'h66);   add_out(3, 4'hE, 8'h66);
        add_out(4, 4'hF, 8'h00);   add_out(5, 4'hF, 8'h00);
        add_out(6, 4'hD, 8'h4F);   add_out(9, 4'hD, 8'h4F);
        add_out(10, 4'hF, 8'h00);  add_out(12, 4'hB, 8'h5B);
        add_out(18, 4'h7, 8'h06);  add_out(21, 4'h7, 8'h06);
        add_out(22, 4'hF, 8'h00);  add_stat(22, 1'b1, 1'b0);
        add_stat(23, 1'b0, 1'b0);  add_out(24, 4'hE, 8'h66);
        add_stat(46, 1'b1, 1'b0);  add_stat(47, 1'b0, 1'b0);
        // Two-frame message requested mid-frame
        add_req(50, 32'h7679_383F, 8'd2);
        add_stat(51, 1'b0, 1'b1);  add_out(66, 4'h7, 8'h06);
        add_stat(70, 1'b1, 1'b1);
        add_out(72, 4'hE, 8'h3F);  add_out(78, 4'hD, 8'h38);
        add_req(80, 32'h1122_3344, 8'd5);
        add_stat(81, 1'b0, 1'b1);
        add_out(84, 4'hB, 8'h79);  add_out(90, 4'h7, 8'h76);
        add_stat(94, 1'b1, 1'b1);
        add_out(96, 4'hE, 8'h3F);  add_out(102, 4'hD, 8'h38);
        add_out(114, 4'h7, 8'h76);
        add_stat(118, 1'b1, 1'b1); add_stat(119, 1'b0, 1'b0);
        add_out(120, 4'hE, 8'h66);
        add_req(121, 32'hAABB_CCDD, 8'd0);
        add_stat(122, 1'b0, 1'b0); add_stat(130, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("reset cc seven_seg", seg_cc, 8'h00);
        check("reset cc digit_en", den_cc, 4'hF);
        check("reset ca seven_seg", seg_ca, 8'hFF);
        check("reset ca digit_en", den_ca, 4'h0);
        check("reset msg_busy", busy_cc, 1'b0);
        check("reset frame_done", fd_cc, 1'b0);
        rst_n = 1'b1;
        k = -1;

        foreach (vecs[i]) begin
            while (k < vecs[i].cyc) tick();
            if (vecs[i].chk_out) check_out("scan", vecs[i].den, vecs[i].seg);
            if (vecs[i].chk_fd) begin
                check($sformatf("k%0d cc frame_done", k), fd_cc, vecs[i].fd);
                check($sformatf("k%0d ca frame_done", k), fd_ca, vecs[i].fd);
            end
            if (vecs[i].chk_busy) check($sformatf("k%0d msg_busy", k), busy_cc, vecs[i].busy);
            if (vecs[i].req) begin
                msg_data   = vecs[i].data;
                msg_frames = vecs[i].frames;
                msg_req    = 1'b1;
            end
        end

        // PWM at brightness 4: pwm_cnt equals k mod 16
        brightness = 4'd4;
        while (k < 144) tick();
        check_out("pwm on", 4'hE, 8'h66);
        while (k < 147) tick();
        check_out("pwm on", 4'hE, 8'h66);
        while (k < 150) tick();
        check_out("pwm off", 4'hF, 8'h00);
        while (k < 163) tick();
        check_out("pwm on", 4'h7, 8'h06);
        while (k < 168) tick();
        check_out("pwm off", 4'hF, 8'h00);
        while (k < 171) tick();
        check_out("pwm off", 4'hF, 8'h00);

        brightness = 4'd0;
        bad = 0;
        while (k < 219) begin
            tick();
            if (den_cc !== 4'hF || seg_cc !== 8'h00) bad++;
        end
        check("brightness0 lit cycles", bad, 0);

        // Invalid BCD nibbles blank their digits
        brightness = 4'hF;
        time_bcd   = 16'h59AF;
        while (k < 240) tick();
        check_out("bcd", 4'hE, 8'h00);
        while (k < 246) tick();
        check_out("bcd", 4'hD, 8'h00);
        while (k < 252) tick();
        check_out("bcd", 4'hB, 8'h6F);
        while (k < 258) tick();
        check_out("bcd", 4'h7, 8'h6D);

        // Reset mid-message, mid-dwell
        while (k < 260) tick();
        msg_data   = 32'h7679_383F;
        msg_frames = 8'd3;
        msg_req    = 1'b1;
        while (k < 265) tick();
        check_out("msg pre-reset", 4'hE, 8'h3F);
        check("msg pre-reset busy", busy_cc, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset cc seven_seg", seg_cc, 8'h00);
        check("async reset cc digit_en", den_cc, 4'hF);
        check("async reset ca seven_seg", seg_ca, 8'hFF);
        check("async reset ca digit_en", den_ca, 4'h0);
        check("async reset msg_busy", busy_cc, 1'b0);
        check("async reset ca msg_busy", busy_ca, 1'b0);
        time_bcd = 16'h1234;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        k = -1;
        tick();
        check_out("after reset", 4'hE, 8'h66);
        check("after reset msg_busy", busy_cc, 1'b0);
        while (k < 24) tick();
        check_out("after reset", 4'hE, 8'h66);
        while (k < 30) tick();
        check("after reset busy later", busy_cc, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
